// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and
// loads the IF/ID register. Optional perf counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6,
    parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_redirect_valid,
    input  logic [31:0]        i_redirect_pc,
    output logic [IMEM_AW-1:0] o_imem_addr,
    input  logic [31:0]        i_imem_data,
    output logic [31:0]        o_pc_out,
    output logic               o_ifid_valid,
    output logic [31:0]        o_ifid_pc,
    output logic [31:0]        o_ifid_pc_plus4,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        o_fetch_cnt,
    output logic [31:0]        o_bubble_cnt,
`endif
    output logic [31:0]        o_ifid_inst
);

    logic [31:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic [31:0] r_ifid_inst;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_load_normal;
    logic        w_load_bubble;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = {i_redirect_pc[31:2], 2'b00};

    // Redirect beats flush beats stall; a bubble is inserted on redirect or flush.
    assign w_load_bubble = i_redirect_valid | i_flush;
    assign w_load_normal = ~i_redirect_valid & ~i_flush & ~i_stall;

    assign o_imem_addr = r_pc[IMEM_AW+1:2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (!i_stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // Bubbles leave ifid_pc/ifid_pc_plus4 untouched; only valid and the word are cleared.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ifid_valid    <= 1'b0;
            r_ifid_pc       <= 32'd0;
            r_ifid_pc_plus4 <= 32'd0;
            r_ifid_inst     <= NOP_INST;
        end else if (w_load_bubble) begin
            r_ifid_valid    <= 1'b0;
            r_ifid_inst     <= NOP_INST;
        end else if (w_load_normal) begin
            r_ifid_valid    <= 1'b1;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_inst     <= i_imem_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_load_normal && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_load_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign o_fetch_cnt  = r_fetch_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
`endif

    assign o_pc_out        = r_pc;
    assign o_ifid_valid    = r_ifid_valid;
    assign o_ifid_pc       = r_ifid_pc;
    assign o_ifid_pc_plus4 = r_ifid_pc_plus4;
    assign o_ifid_inst     = r_ifid_inst;

endmodule
